// File: rtl/run_ctl_if.sv
// Host, data-memory, processor and result-stream signals of the run controller.
// The slave modport is the controller's view; master is the surrounding system.
interface run_ctl_if;
  logic        go;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_dat;
  logic        dm_wr_en;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wdat;
  logic [7:0]  dm_rdat;
  logic        dut_start;
  logic        dut_req;
  logic        dut_done;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_dat;
  logic        busy;
  logic        run_done;
  logic        timeout;
  logic [15:0] cyc_cnt;

  modport slave (
    input  go, ld_valid, ld_dat, dm_rdat, dut_done, res_ready,
    output ld_ready, dm_wr_en, dm_addr, dm_wdat, dut_start, dut_req,
           res_valid, res_dat, busy, run_done, timeout, cyc_cnt
  );

  modport master (
    output go, ld_valid, ld_dat, dm_rdat, dut_done, res_ready,
    input  ld_ready, dm_wr_en, dm_addr, dm_wdat, dut_start, dut_req,
           res_valid, res_dat, busy, run_done, timeout, cyc_cnt
  );
endinterface

// File: rtl/run_ctl.sv
// Run controller: preloads data memory, starts and watches a processor run,
// then streams result bytes back, with a cycle-count watchdog.
module run_ctl #(
  parameter int unsigned N_LOAD    = 8,
  parameter int unsigned N_READ    = 4,
  parameter logic [7:0]  LD_BASE   = 8'h00,
  parameter logic [7:0]  RD_BASE   = 8'h40,
  parameter int unsigned START_CYC = 2,
  parameter logic [15:0] MAX_CYC   = 16'd4096
) (
  input logic      clk,
  input logic      reset,
  run_ctl_if.slave bus
);

  localparam int unsigned IdxMax = (N_LOAD > N_READ) ? N_LOAD : N_READ;
  localparam int unsigned IdxW   = (IdxMax > 1) ? $clog2(IdxMax) : 1;
  localparam int unsigned StW    = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StRead  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [StW-1:0]  st_cnt_q, st_cnt_d;
  logic [15:0]     cyc_cnt_q, cyc_cnt_d;
  logic            timeout_q, timeout_d;
  logic            run_done_q, run_done_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    st_cnt_d   = st_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    timeout_d  = timeout_q;
    run_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.go) begin
          idx_d     = '0;
          timeout_d = 1'b0;
          cyc_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (bus.ld_valid) begin
          if (idx_q == IdxW'(N_LOAD - 1)) begin
            idx_d    = '0;
            st_cnt_d = '0;
            state_d  = StStart;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StStart: begin
        if (st_cnt_q == StW'(START_CYC - 1)) begin
          state_d = StRun;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Completion takes priority over the watchdog in the final cycle.
        if (bus.dut_done) begin
          idx_d   = '0;
          state_d = StRead;
        end else if (cyc_cnt_q == MAX_CYC - 16'd1) begin
          timeout_d = 1'b1;
          state_d   = StErr;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end
      StRead: begin
        if (bus.res_ready) begin
          if (idx_q == IdxW'(N_READ - 1)) begin
            idx_d      = '0;
            run_done_d = 1'b1;
            state_d    = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      st_cnt_q   <= '0;
      cyc_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      st_cnt_q   <= st_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      timeout_q  <= timeout_d;
      run_done_q <= run_done_d;
    end
  end

  logic in_load, in_read;
  assign in_load = (state_q == StLoad);
  assign in_read = (state_q == StRead);

  // All outputs decode from reset-cleared state, so they drop to 0 as soon as reset asserts.
  assign bus.ld_ready  = in_load;
  assign bus.dm_wr_en  = in_load && bus.ld_valid;
  assign bus.dm_addr   = in_load ? LD_BASE + 8'(idx_q) :
                         in_read ? RD_BASE + 8'(idx_q) : 8'h00;
  assign bus.dm_wdat   = (in_load && bus.ld_valid) ? bus.ld_dat : 8'h00;
  assign bus.dut_start = (state_q == StStart);
  assign bus.dut_req   = (state_q == StRun);
  assign bus.res_valid = in_read;
  assign bus.res_dat   = in_read ? bus.dm_rdat : 8'h00;
  assign bus.busy      = (state_q != StIdle);
  assign bus.run_done  = run_done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cyc_cnt   = cyc_cnt_q;

endmodule

// File: doc/run_ctl.md
RUN_CTL -- requirements
Module: run_ctl

Interface
REQ-001 Parameters: N_LOAD, default 8, number of bytes preloaded into data memory per run.
REQ-002 Parameters: N_READ, default 4, number of result bytes read back per run.
REQ-003 Parameters: LD_BASE = 8'h00, RD_BASE = 8'h40, START_CYC = 2, MAX_CYC = 16'd4096.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous reset, active-low.
REQ-006 go  in  1  host request to launch one run.
REQ-007 ld_valid / ld_ready  in / out  1 / 1  load-byte handshake.
REQ-008 ld_dat  in  8  load byte.
REQ-009 dm_wr_en  out  1  data-memory host-port write enable.
REQ-010 dm_addr  out  8  data-memory host-port address.
REQ-011 dm_wdat  out  8  write data.
REQ-012 dm_rdat  in  8  read data; combinational read of dm_addr.
REQ-013 dut_start  out  1  processor start, which resets its program counter.
REQ-014 dut_req  out  1  processor run request.
REQ-015 dut_done  in  1  processor completion flag.
REQ-016 res_valid / res_ready  out / in  1 / 1  result-byte handshake.
REQ-017 res_dat  out  8  result byte.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 run_done  out  1  one-cycle pulse marking a completed run.
REQ-020 timeout  out  1  sticky flag: processor never raised dut_done.
REQ-021 cyc_cnt  out  16  count of processor run cycles in the last run.

Function
REQ-022 FSM states: IDLE, LOAD, START, RUN, READ, ERR. One-hot or binary encoding is permitted.
REQ-023 IDLE: on go=1, clear idx, timeout and cyc_cnt, then enter LOAD. go is ignored in every other state.
REQ-024 LOAD: ld_ready=1.
- Each cycle with ld_valid&&ld_ready: dm_wr_en=1 combinationally, dm_addr=LD_BASE+idx (mod 256), dm_wdat=ld_dat, idx++.
- After the N_LOAD-th transfer, enter START next cycle.
REQ-025 dm_wr_en is 0 in every state except LOAD with ld_valid=1.
REQ-026 START: dut_start=1 for exactly START_CYC consecutive cycles, then enter RUN. dut_done is ignored in START.
REQ-027 RUN: dut_req=1; cyc_cnt increments by 1 every RUN cycle, beginning at 0 in the first RUN cycle.
- If dut_done=1 is sampled in any RUN cycle, including the first: enter READ, idx=0, cyc_cnt frozen.
- If cyc_cnt==MAX_CYC-1 and dut_done=0: enter ERR.
- If dut_done=1 in that same cycle, done wins and no ERR occurs.
REQ-028 dut_done is ignored outside RUN.
REQ-029 READ: dm_addr=RD_BASE+idx (mod 256); res_valid=1; res_dat=dm_rdat.
- A transfer occurs when res_ready=1; idx++ on each transfer.
- With res_ready=0, res_valid, res_dat and dm_addr hold stable.
- After the N_READ-th transfer: run_done=1 for one cycle and enter IDLE.
REQ-030 ERR: timeout is set and stays set until the next accepted go; the block returns to IDLE the next cycle with no run_done pulse.
REQ-031 cyc_cnt holds its final value in IDLE until the next accepted go.
REQ-032 idx is wide enough for max(N_LOAD, N_READ) and never wraps within a phase.

Reset
REQ-033 While reset=0, the following apply immediately and asynchronously:
- state=IDLE, idx=0, cyc_cnt=0.
- Every output is 0, including dm_addr and res_dat.
REQ-034 Reset asserted mid-operation abandons the run: no run_done pulse, and timeout is cleared. After release, the block waits in IDLE for go.
REQ-035 Memory contents written before reset are not the block's concern.

Verification
REQ-036 Nominal run:
- Stimulus: go, bytes 0x11..0x18 offered back-to-back, dut_done raised 10 cycles after RUN entry, res_ready=1.
- Response: writes to 0x00..0x07; dut_start high 2 cycles; cyc_cnt=10; res_dat = mem[0x40..0x43]; one run_done pulse.
REQ-037 Load stall:
- Stimulus: ld_valid toggled 1,0,0,1…
- Response: exactly 8 writes; no write while ld_valid=0; addresses contiguous.
REQ-038 Read back-pressure:
- Stimulus: res_ready held low 5 cycles on byte 2.
- Response: res_dat and dm_addr=0x42 stable for all 5 cycles; no byte lost or duplicated.
REQ-039 Timeout:
- Stimulus: dut_done held 0.
- Response: ERR after 4096 RUN cycles; timeout=1, no run_done; next go clears timeout.
- Corner: dut_done=1 exactly at cycle 4095 results in READ, not ERR.
REQ-040 Spurious and early done:
- Stimulus: dut_done=1 during IDLE/LOAD/START.
- Response: ignored; a dut_done already high at the first RUN cycle gives cyc_cnt=0.
REQ-041 Reset mid-RUN:
- Stimulus: reset=0 at RUN cycle 7.
- Response: outputs 0 without waiting for a clock edge; IDLE after release; a new go completes normally.
